fxp_alu_seq: RTL and testbench

- Parametrised sign-magnitude fixed-point arithmetic unit with a start/done handshake. Successor to the fixed 8.8 FPU FSM.
- Generalised integer/fraction widths, selectable saturation, sequential (iterative) multiplier and divider, and overflow / divide-by-zero flags.
- Sits behind the operand registers of the arithmetic datapath. One operation in flight at a time.

---
 rtl/fxp_alu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fxp_alu_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fxp_alu_seq.sv
// Sign-magnitude fixed-point arithmetic unit with a start/done handshake.
// Add/sub finish in one execute cycle. Multiply is a W-step shift-add.
// Divide is a (W+FRAC_W)-step restoring division.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start, S            request (sampled in IDLE only); op: 00 add, 01 sub, 10 mul, 11 div
//   sign_bit_a/b        operand signs (1 = negative)
//   int_part_a/b        operand integer magnitudes
//   frac_part_a/b       operand fraction magnitudes
//   sign_bit_result     result sign (never set for a zero magnitude)
//   int_part_result     result integer magnitude
//   frac_part_result    result fraction magnitude
//   overflow            result magnitude did not fit in W bits
//   div_by_zero         division with a zero divisor
//   busy                high while executing
//   done                one-cycle completion pulse
module fxp_alu_seq #(
    parameter int unsigned INT_W    = 8,
    parameter int unsigned FRAC_W   = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        S,
    input  logic              sign_bit_a,
    input  logic [INT_W-1:0]  int_part_a,
    input  logic [FRAC_W-1:0] frac_part_a,
    input  logic              sign_bit_b,
    input  logic [INT_W-1:0]  int_part_b,
    input  logic [FRAC_W-1:0] frac_part_b,
    output logic              sign_bit_result,
    output logic [INT_W-1:0]  int_part_result,
    output logic [FRAC_W-1:0] frac_part_result,
    output logic              overflow,
    output logic              div_by_zero,
    output logic              busy,
    output logic              done
);

    localparam int unsigned W     = INT_W + FRAC_W;
    localparam int unsigned L     = W + FRAC_W;
    localparam int unsigned CNT_W = $clog2(L + 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q;
    logic               sa_q, sb_q;
    logic [W-1:0]       ma_q, mb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*W-1:0]     prod_q;
    logic [W-1:0]       rem_q;
    logic [L-1:0]       quo_q;
    logic               sign_q, ovf_q, dbz_q;
    logic [W-1:0]       mag_q;

    logic [W-1:0]       ma_in, mb_in;
    logic [CNT_W-1:0]   cnt_load;
    logic               last;

    assign ma_in = {int_part_a, frac_part_a};
    assign mb_in = {int_part_b, frac_part_b};
    assign last  = (cnt_q == CNT_W'(1));

    always_comb begin
        unique case (S)
            2'b10:   cnt_load = CNT_W'(W);
            2'b11:   cnt_load = (mb_in == '0) ? CNT_W'(1) : CNT_W'(L);
            default: cnt_load = CNT_W'(1);
        endcase
    end

    // One iteration of the multiplier: conditionally add Ma into the upper half,
    // then shift the whole product/multiplier register right.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod_step;
    // One iteration of restoring division: shift in the next dividend bit.
    logic [W:0]     rem_sh;
    logic           rem_ge;
    logic [W-1:0]   rem_step;
    logic [L-1:0]   quo_step;

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, ma_q} : '0);
        prod_step = {mul_sum, prod_q[W-1:1]};
        rem_sh    = {rem_q, quo_q[L-1]};
        rem_ge    = (rem_sh >= {1'b0, mb_q});
        rem_step  = rem_ge ? W'(rem_sh - {1'b0, mb_q}) : rem_sh[W-1:0];
        quo_step  = {quo_q[L-2:0], rem_ge};
    end

    // Result of the operation, valid on the last execute cycle.
    logic [W:0]   sum;
    logic         eff_sb;
    logic [W-1:0] raw_mag, res_mag;
    logic         raw_sign, res_sign, res_ovf, res_dbz;

    always_comb begin
        sum      = {1'b0, ma_q} + {1'b0, mb_q};
        eff_sb   = sb_q ^ op_q[0];
        raw_mag  = '0;
        raw_sign = sa_q ^ sb_q;
        res_ovf  = 1'b0;
        res_dbz  = 1'b0;
        unique case (op_q)
            2'b10: begin
                raw_mag = prod_step[W+FRAC_W-1:FRAC_W];
                res_ovf = |prod_step[2*W-1:W+FRAC_W];
            end
            2'b11: begin
                if (mb_q == '0) begin
                    res_dbz = 1'b1;
                    raw_mag = SATURATE ? '1 : '0;
                end else begin
                    raw_mag = quo_step[W-1:0];
                    res_ovf = |quo_step[L-1:W];
                end
            end
            default: begin
                if (sa_q == eff_sb) begin
                    raw_mag  = sum[W-1:0];
                    res_ovf  = sum[W];
                    raw_sign = sa_q;
                end else if (ma_q >= mb_q) begin
                    raw_mag  = ma_q - mb_q;
                    raw_sign = sa_q;
                end else begin
                    raw_mag  = mb_q - ma_q;
                    raw_sign = eff_sb;
                end
            end
        endcase
        res_mag  = (res_ovf && SATURATE) ? '1 : raw_mag;
        res_sign = (res_mag == '0) ? 1'b0 : raw_sign;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StExec;
            StExec:  if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q   <= S;
                        sa_q   <= sign_bit_a;
                        sb_q   <= sign_bit_b;
                        ma_q   <= ma_in;
                        mb_q   <= mb_in;
                        cnt_q  <= cnt_load;
                        prod_q <= {{W{1'b0}}, mb_in};
                        rem_q  <= '0;
                        quo_q  <= {ma_in, {FRAC_W{1'b0}}};
                    end
                end
                StExec: begin
                    cnt_q  <= cnt_q - CNT_W'(1);
                    prod_q <= prod_step;
                    rem_q  <= rem_step;
                    quo_q  <= quo_step;
                    if (last) begin
                        sign_q <= res_sign;
                        mag_q  <= res_mag;
                        ovf_q  <= res_ovf;
                        dbz_q  <= res_dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sign_bit_result  = sign_q;
    assign int_part_result  = mag_q[W-1:FRAC_W];
    assign frac_part_result = mag_q[FRAC_W-1:0];
    assign overflow         = ovf_q;
    assign div_by_zero      = dbz_q;
    assign busy             = (state_q == StExec);
    assign done             = (state_q == StDone);

endmodule

// File: tb/tb_fxp_alu_seq.sv
// Three builds share one stimulus: 8.8 saturating, 8.8 wrapping, 4.12 saturating.
// All have W = 16, so the same 16-bit magnitudes feed each, split per build.
module tb_fxp_alu_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  s;
    logic        sa, sb;
    logic [15:0] ma, mb;

    wire [7:0]  i0, f0, i1, f1;
    wire [3:0]  i2;
    wire [11:0] f2;
    wire [2:0]  sr, ov, dz, bz, dn;
    wire [15:0] mr [3];

    assign mr[0] = {i0, f0};
    assign mr[1] = {i1, f1};
    assign mr[2] = {i2, f2};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fxp_alu_seq #(.INT_W(8), .FRAC_W(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .start(start), .S(s),
        .sign_bit_a(sa), .int_part_a(ma[15:8]), .frac_part_a(ma[7:0]),
        .sign_bit_b(sb), .int_part_b(mb[15:8]), .frac_part_b(mb[7:0]),
        .sign_bit_result(sr[0]), .int_part_result(i0), .frac_part_result(f0),
        .overflow(ov[0]), .div_by_zero(dz[0]), .busy(bz[0]), .done(dn[0])
    );

    fxp_alu_seq #(.INT_W(8), .FRAC_W(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .S(s),
        .sign_bit_a(sa), .int_part_a(ma[15:8]), .frac_part_a(ma[7:0]),
        .sign_bit_b(sb), .int_part_b(mb[15:8]), .frac_part_b(mb[7:0]),
        .sign_bit_result(sr[1]), .int_part_result(i1), .frac_part_result(f1),
        .overflow(ov[1]), .div_by_zero(dz[1]), .busy(bz[1]), .done(dn[1])
    );

    fxp_alu_seq #(.INT_W(4), .FRAC_W(12), .SATURATE(1'b1)) u_q412 (
        .clk(clk), .reset(reset), .start(start), .S(s),
        .sign_bit_a(sa), .int_part_a(ma[15:12]), .frac_part_a(ma[11:0]),
        .sign_bit_b(sb), .int_part_b(mb[15:12]), .frac_part_b(mb[11:0]),
        .sign_bit_result(sr[2]), .int_part_result(i2), .frac_part_result(f2),
        .overflow(ov[2]), .div_by_zero(dz[2]), .busy(bz[2]), .done(dn[2])
    );

    task automatic check(input string tag, input longint unsigned obs,
                         input longint unsigned exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the real magnitudes.
    // Returns {sign, magnitude[15:0], overflow, div_by_zero}.
    function automatic logic [18:0] model(input logic [1:0] op, input logic a_s, b_s,
                                          input logic [15:0] a, b, input int fw,
                                          input bit sat);
        longint unsigned ua, ub, t;
        logic            sgn, bs, ovf, dbz;
        logic [15:0]     m;
        ua  = a;
        ub  = b;
        ovf = 1'b0;
        dbz = 1'b0;
        sgn = a_s ^ b_s;
        if (op[1] == 1'b0) begin
            bs = b_s ^ op[0];
            if (a_s == bs) begin
                t = ua + ub;
                sgn = a_s;
            end else if (ua >= ub) begin
                t = ua - ub;
                sgn = a_s;
            end else begin
                t = ub - ua;
                sgn = bs;
            end
        end else if (op[0] == 1'b0) begin
            t = (ua * ub) >> fw;
        end else if (ub == 0) begin
            dbz = 1'b1;
            t = sat ? 64'hFFFF : 64'h0;
        end else begin
            t = (ua << fw) / ub;
        end
        ovf = (t > 64'hFFFF);
        m   = (ovf && sat) ? 16'hFFFF : t[15:0];
        if (m == 16'h0) sgn = 1'b0;
        return {sgn, m, ovf, dbz};
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [15:0] b, input int fw);
        if (op == 2'b10) return 17;
        if (op == 2'b11 && b != 16'h0) return 16 + fw + 1;
        return 2;
    endfunction

    // Issue one operation, scramble inputs after the start edge, observe a fixed
    // window, then compare every build against the reference. With poke set,
    // start is pulsed again while the operation is still executing.
    task automatic run_op(input string name, input logic [1:0] op, input logic a_s, b_s,
                          input logic [15:0] a, b, input bit poke);
        int          lat[3];
        int          nd[3];
        int          nbusy;
        int          fw[3]   = '{8, 8, 12};
        bit          satv[3] = '{1'b1, 1'b0, 1'b1};
        logic [18:0] exp;
        s = op; sa = a_s; sb = b_s; ma = a; mb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = 2'($urandom); sa = 1'($urandom); sb = 1'($urandom);
        ma = 16'($urandom); mb = 16'($urandom);
        nbusy = int'(bz[0]);
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0;
            nd[k]  = 0;
        end
        for (int c = 2; c <= 40; c++) begin
            if (poke && c == 5) start = 1'b1;
            if (poke && c == 6) start = 1'b0;
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (dn[k]) begin
                    nd[k]++;
                    if (lat[k] == 0) lat[k] = c;
                end
            end
            nbusy += int'(bz[0]);
        end
        check($sformatf("%s busy_cycles", name), nbusy, latency(op, b, 8) - 1);
        for (int k = 0; k < 3; k++) begin
            exp = model(op, a_s, b_s, a, b, fw[k], satv[k]);
            check($sformatf("%s[%0d] latency", name, k), lat[k], latency(op, b, fw[k]));
            check($sformatf("%s[%0d] done_count", name, k), nd[k], 1);
            check($sformatf("%s[%0d] sign", name, k), sr[k], exp[18]);
            check($sformatf("%s[%0d] magnitude", name, k), mr[k], exp[17:2]);
            check($sformatf("%s[%0d] overflow", name, k), ov[k], exp[1]);
            check($sformatf("%s[%0d] div_by_zero", name, k), dz[k], exp[0]);
        end
    endtask

    initial begin
        int          ndone;
        logic [1:0]  rop;
        logic [15:0] ra, rb;

        reset = 1'b1; start = 1'b0; s = 2'b00; sa = 1'b0; sb = 1'b0;
        ma = 16'h0; mb = 16'h0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset[%0d] magnitude", k), mr[k], 0);
        end
        check("reset flags", {sr, ov, dz, bz, dn}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op("add",       2'b00, 1'b0, 1'b0, 16'h0380, 16'h0140, 1'b0);
        run_op("sub",       2'b01, 1'b0, 1'b0, 16'h0100, 16'h0280, 1'b0);
        run_op("sub_equal", 2'b01, 1'b0, 1'b0, 16'h0200, 16'h0200, 1'b0);
        run_op("mul",       2'b10, 1'b1, 1'b0, 16'h0280, 16'h0400, 1'b0);
        run_op("mul_ovf",   2'b10, 1'b0, 1'b0, 16'h1400, 16'h1400, 1'b0);
        run_op("div",       2'b11, 1'b0, 1'b0, 16'h0780, 16'h0200, 1'b0);
        run_op("div_trunc", 2'b11, 1'b0, 1'b0, 16'h0100, 16'h0300, 1'b0);
        run_op("div_ovf",   2'b11, 1'b0, 1'b0, 16'hC800, 16'h0080, 1'b0);
        run_op("div_zero",  2'b11, 1'b0, 1'b1, 16'h0500, 16'h0000, 1'b0);
        run_op("mul_q412",  2'b10, 1'b0, 1'b0, 16'h1800, 16'h1800, 1'b0);
        run_op("mul_poke",  2'b10, 1'b1, 1'b1, 16'h0280, 16'h0180, 1'b1);

        // Reset in the middle of a multiply: outputs clear at once, no done follows.
        s = 2'b10; sa = 1'b1; sb = 1'b0; ma = 16'h0280; mb = 16'h0400; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midreset[%0d] magnitude", k), mr[k], 0);
        end
        check("midreset flags", {sr, ov, dz, bz, dn}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (dn != 3'b000) ndone++;
        end
        check("midreset no_done", ndone, 0);
        run_op("add_after_reset", 2'b00, 1'b1, 1'b1, 16'h1234, 16'h0F0F, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom) >> $urandom_range(0, 8);
            rb  = 16'($urandom) >> $urandom_range(0, 10);
            if ($urandom_range(0, 7) == 0) rb = 16'h0;
            run_op($sformatf("rand%0d", i), rop, 1'($urandom), 1'($urandom), ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
